// File: rtl/addsub_arbiter.sv
// Round-robin scheduler sharing one (W+1)-bit signed add/subtract unit between two requesters.
// Operands are sign-extended, held on the unit for LAT cycles, and the result is returned with owner ID and overflow.
//
// state | meaning
// IDLE  | waiting for a request; grant by round-robin pointer when both are valid
// BUSY  | operands held on the shared unit; counting down the unit latency
// DONE  | result held on rsp_*; waiting for the consumer handshake
module addsub_arbiter #(
    parameter int W   = 64,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_sub,
    input  logic [W-1:0] req0_x,
    input  logic [W-1:0] req0_y,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_sub,
    input  logic [W-1:0] req1_x,
    input  logic [W-1:0] req1_y,
    output logic [W:0]   au_x,
    output logic [W:0]   au_y,
    output logic         au_sub,
    input  logic [W:0]   au_z,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W:0]   rsp_z,
    output logic         rsp_ovf
);

    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          ptr;
    logic [CW-1:0] cnt;
    logic          grant;
    logic          any_valid;
    logic          accept;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ptr;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign any_valid  = req0_valid | req1_valid;
    assign accept     = (state == IDLE) & any_valid;
    assign req0_ready = accept & ~grant;
    assign req1_ready = accept & grant;
    assign rsp_valid  = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_valid) state_nxt = BUSY;
            BUSY: if (cnt == '0) state_nxt = DONE;
            DONE: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= 1'b0;
            cnt     <= '0;
            au_x    <= '0;
            au_y    <= '0;
            au_sub  <= 1'b0;
            rsp_id  <= 1'b0;
            rsp_z   <= '0;
            rsp_ovf <= 1'b0;
        end else begin
            if (accept) begin
                if (grant) begin
                    au_x   <= {req1_x[W-1], req1_x};
                    au_y   <= {req1_y[W-1], req1_y};
                    au_sub <= req1_sub;
                end else begin
                    au_x   <= {req0_x[W-1], req0_x};
                    au_y   <= {req0_y[W-1], req0_y};
                    au_sub <= req0_sub;
                end
                rsp_id <= grant;
                cnt    <= CW'(LAT - 1);
                ptr    <= ~grant;
            end else if (state == BUSY) begin
                if (cnt == '0) begin
                    rsp_z   <= au_z;
                    // top two bits disagree when the result needs the extra bit
                    rsp_ovf <= au_z[W] ^ au_z[W-1];
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin scheduler that shares one 65-bit signed add/subtract unit of the ALU-64 between two requesters. It accepts 64-bit signed operand pairs over valid/ready handshakes and sign-extends them to 65 bits. It drives the shared unit for a fixed latency, then captures the 65-bit result and returns it with the requester ID and an overflow flag. The block sits between the ALU front-end ports and the shared adder/substractor datapath.

## Interface
- W, 64, operand width; the shared unit and the result are W+1 bits wide.
- LAT, 1, cycles from operands applied to the unit until au_z is valid; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  requester's operation is accepted this edge
- req0_sub / req1_sub  in  1  0 = x+y, 1 = x−y
- req0_x, req0_y / req1_x, req1_y  in  W  signed operands
- au_x, au_y  out  W+1  sign-extended operands to the shared unit
- au_sub  out  1  operation select to the shared unit
- au_z  in  W+1  shared unit result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes the result
- rsp_id  out  1  requester that owns rsp_z
- rsp_z  out  W+1  signed result
- rsp_ovf  out  1  result does not fit in W signed bits

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Grant goes to the round-robin pointer if both requesters are valid; otherwise to the single valid requester.
  - reqN_ready = (state==IDLE) & grant==N. It is combinational on the valid inputs, and at most one ready is high.
  - On the accepting edge, the block latches {x[W-1],x} into au_x and {y[W-1],y} into au_y.
  - On the same edge it latches sub into au_sub and the requester ID into rsp_id.
  - It also loads cnt = LAT−1, sets the pointer to the other requester, and moves to BUSY.
- BUSY:
  - au_x, au_y and au_sub stay stable.
  - On each edge, if cnt==0 the block captures au_z into rsp_z, sets rsp_ovf = au_z[W] ^ au_z[W-1] and moves to DONE. Otherwise cnt decrements.
- DONE:
  - rsp_valid=1; rsp_z, rsp_id and rsp_ovf hold stable.
  - On an edge with rsp_ready=1 the block returns to IDLE.
  - Both reqN_ready are low.
- Only one operation is in flight; no new request is accepted before the response handshake.
- Arithmetic is two's complement at W+1 bits; a 65-bit result never wraps for 64-bit inputs.
- The pointer advances only on a grant. An idle cycle does not change it.

## Timing
- Reset (async assert, any state): state=IDLE and pointer=0 (requester 0 preferred).
- Reset values: au_x=0, au_y=0, au_sub=0, rsp_valid=0, rsp_id=0, rsp_z=0, rsp_ovf=0, cnt=0.
- Reset mid-BUSY or mid-DONE abandons the operation silently; no response is produced.
- Let accept edge = E0. au_* are valid after E0. au_z is sampled at edge E0+LAT, and rsp_valid rises after E0+LAT.
- rsp_valid and rsp_ready high at edge Ed: rsp_valid falls after Ed, and reqN_ready may be high in the following cycle.
- The earliest next accept is edge Ed+1. Best-case throughput is one operation per LAT+2 cycles.
- A request withdrawn (valid dropped) before an accept edge is not accepted and does not move the pointer.
- rsp_ready held high while not in DONE has no effect.

## Test plan
- Single add, LAT=1: req0 applies x=5, y=7, sub=0. Expect req0_ready high the same cycle. One edge after accept, rsp_valid=1, rsp_z=12, rsp_id=0, rsp_ovf=0.
- Subtract, negative result: req1 applies x=3, y=10, sub=1. Expect rsp_z = −7 (65'h1_FFFF_FFFF_FFFF_FFF9), rsp_id=1, rsp_ovf=0.
- Overflow: x=64'h7FFF_FFFF_FFFF_FFFF, y=1, add. Expect rsp_z=65'h0_8000_0000_0000_0000 and rsp_ovf=1. Also x=64'h8000_0000_0000_0000, y=1, sub: expect rsp_z=65'h1_7FFF_FFFF_FFFF_FFFF and rsp_ovf=1.
- Fairness: both requesters hold valid continuously after reset with distinct operands. Grants alternate 0,1,0,1 over 4 operations, and each rsp_id matches the operand set.
- Backpressure and latency, LAT=4: hold rsp_ready=0 for 5 cycles after rsp_valid rises.
  - rsp_valid rises exactly 4 edges after accept.
  - rsp_z and rsp_id stay stable and both reqN_ready stay 0 while rsp_ready is low.
  - Accept resumes one cycle after rsp_ready goes high.
- Reset mid-operation: assert rst_n=0 during BUSY. All outputs go to 0 immediately and rsp_valid never rises. With both requesters then valid, the first grant goes to req0.
